tt3_sweep_ctrl: RTL and testbench
=================================

# tt3_sweep_ctrl

Sweep controller for one 3-input NOR/NOT logic netlist, such as the Cello-style 3-input designs. On a start request it drives all eight input combinations onto the netlist inputs `in1`/`in2`/`in3` in order. For each combination it waits a programmable settle time, samples the netlist output, and assembles the 8-bit truth-table signature in the design-naming convention (e.g. 0x39). It sits between a test/characterisation sequencer and the combinational netlist under evaluation.

## Interface
- `SETTLE_CYCLES`, default 4: cycles each input vector is held before sampling; legal range 1..255.
- `EXPECTED`, default 8'h39: reference signature for the compare feature.

- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  sweep request; single-cycle pulse or level, honoured only in IDLE.
- `abort`  input  1  terminates a running sweep.
- `dut_out`  input  1  netlist output, synchronous to `clk`.
- `in1`, `in2`, `in3`  output  1 each  netlist inputs, registered.
- `busy`  output  1  high from the cycle after start acceptance until DONE is left.
- `done`  output  1  one-cycle pulse on sweep completion; never pulses on abort.
- `tt_sig`  output  8  truth-table signature.
- `match`  output  1  signature equals `EXPECTED`; see Configuration.

## Operation
- State machine: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `start`=1 moves to SETTLE.
  - On that move: vector index `vec` is set to 0, settle counter `cnt` is set to 0, and `tt_sig` and `match` are cleared.
- SETTLE:
  - Outputs drive {`in1`,`in2`,`in3`} = `vec` (`in1` is the MSB).
  - `cnt` increments each cycle.
  - When `cnt`==`SETTLE_CYCLES`-1, the next state is SAMPLE.
- SAMPLE:
  - `tt_sig[7-vec]` is set from `dut_out`; vector 000 lands in bit 7.
  - If `vec`==7, the next state is DONE.
  - Otherwise `vec` increments, `cnt` is set to 0, and the next state is SETTLE. The new vector appears on the outputs in the same cycle SETTLE is entered.
- DONE:
  - `done`=1 for exactly one cycle.
  - `tt_sig` is held; the compare result is registered into `match` if enabled.
  - Next state is IDLE.
- In IDLE and DONE the inputs are driven to 000, and `tt_sig` holds its last value.
- `start` while `busy` is ignored; there is no queuing.
- `abort` in SETTLE or SAMPLE returns to IDLE on the next edge:
  - the inputs return to 000;
  - bits already captured stay in `tt_sig`; the rest stay 0;
  - `done` and `match` are not updated.
- `abort` in IDLE or DONE has no effect.
- `abort` and `start` both high in IDLE: `start` wins, so a sweep begins.
- `vec` is 3 bits and `cnt` is 8 bits. `vec` is not incremented past 7, so there is no wrap.

## Timing
- Reset values: state IDLE; `in1`/`in2`/`in3`=0; `busy`=0; `done`=0; `tt_sig`=8'h00; `match`=0; `vec`=0; `cnt`=0.
- Reset is asynchronous: assertion takes effect immediately, including mid-sweep.
- Start is accepted at edge E. Each vector occupies `SETTLE_CYCLES`+1 cycles.
- `done` is high in cycle E+8·(`SETTLE_CYCLES`+1)+1. `busy` is low in the following cycle.
- `dut_out` is sampled `SETTLE_CYCLES` cycles after the vector is driven.
- A new `start` is accepted at the earliest one cycle after `done`.

## Configuration
- Macro `TT_SWEEP_CHECK_EN`.
- Defined:
  - In DONE, `match` is registered as (`tt_sig` final value == `EXPECTED`).
  - `match` holds until the next start acceptance or reset.
- Undefined:
  - The comparator and `match` register are absent; `match` is tied to 0.
  - `EXPECTED` is unused.

## Test plan
- Model DUT `dut_out`=(`in1`&~`in3`)^`in2`, `SETTLE_CYCLES`=4, pulse `start` -> `done` at start+41 cycles; `tt_sig`=8'h39; `match`=1 with `TT_SWEEP_CHECK_EN` defined, 0 without.
- Model DUT `dut_out`=0, then `dut_out`=1 -> `tt_sig`=8'h00, then 8'hFF; `match`=0 in both with `EXPECTED`=8'h39; each vector 000..111 is held exactly 5 cycles, in order.
- `SETTLE_CYCLES`=1 with the 0x39 model -> each vector held 2 cycles, `done` at start+17, `tt_sig`=8'h39.
- `abort` during the SETTLE of vector 3 -> IDLE next edge, inputs 000, `tt_sig[7:5]` reflect vectors 0..2, `tt_sig[4:0]`=0, no `done` pulse.
- `start` held high for the whole sweep -> only one sweep until `done`. With `start` still high after `done`, a second sweep begins the cycle after `done` and clears `tt_sig` to 0.
- Assert `rst_n` low mid-sweep -> all outputs take their reset values immediately. After release, idle with no `done` until a new `start`.

Source files
------------

// File: rtl/tt3_sweep_ctrl_if.sv
// Sequencer <-> sweep-controller signal bundle: sweep control, netlist drive/sense and result.
// master = test sequencer side (also supplies the netlist output), slave = tt3_sweep_ctrl.
interface tt3_sweep_ctrl_if;
    localparam int unsigned SIG_W = 8;

    logic             start;
    logic             abort;
    logic             dut_out;
    logic             in1;
    logic             in2;
    logic             in3;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] tt_sig;
    logic             match;

    modport master (
        output start, abort, dut_out,
        input  in1, in2, in3, busy, done, tt_sig, match
    );

    modport slave (
        input  start, abort, dut_out,
        output in1, in2, in3, busy, done, tt_sig, match
    );
endinterface

// File: rtl/tt3_sweep_ctrl.sv
// Truth-table sweep controller for a 3-input netlist: walks vectors 000..111, samples the
// netlist after a settle time and builds the 8-bit signature. Optional compare: TT_SWEEP_CHECK_EN.
module tt3_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECTED      = 8'h39
) (
    input  logic           clk,
    input  logic           rst_n,
    tt3_sweep_ctrl_if.slave sw
);

    localparam int unsigned VEC_W = 3;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SIG_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [VEC_W-1:0]   r_vec;
    logic [VEC_W-1:0]   w_vec_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SIG_W-1:0]   r_tt_sig;
    logic [SIG_W-1:0]   w_tt_sig_nxt;
    logic [VEC_W-1:0]   r_in;
    logic [VEC_W-1:0]   w_in_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, datapath next values and registered-output next values
    always_comb begin
        w_state_nxt  = r_state;
        w_vec_nxt    = r_vec;
        w_cnt_nxt    = r_cnt;
        w_tt_sig_nxt = r_tt_sig;

        unique case (r_state)
            ST_IDLE: begin
                if (sw.start) begin
                    w_state_nxt  = ST_SETTLE;
                    w_vec_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_tt_sig_nxt = '0;
                end
            end
            ST_SETTLE: begin
                if (sw.abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (sw.abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    // vector 000 lands in the MSB
                    w_tt_sig_nxt[VEC_W'(3'd7 - r_vec)] = sw.dut_out;
                    if (r_vec == VEC_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_vec_nxt   = r_vec + VEC_W'(1);
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_in_nxt   = ((w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE)) ? w_vec_nxt : '0;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec    <= '0;
            r_cnt    <= '0;
            r_tt_sig <= '0;
            r_in     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_vec    <= w_vec_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tt_sig <= w_tt_sig_nxt;
            r_in     <= w_in_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign sw.in1    = r_in[2];
    assign sw.in2    = r_in[1];
    assign sw.in3    = r_in[0];
    assign sw.busy   = r_busy;
    assign sw.done   = r_done;
    assign sw.tt_sig = r_tt_sig;

`ifdef TT_SWEEP_CHECK_EN
    logic r_match;
    logic w_match_clr;
    logic w_match_load;

    assign w_match_clr  = (r_state == ST_IDLE) && sw.start;
    assign w_match_load = (r_state == ST_DONE);

    // Compare is taken while in DONE, so it reflects the fully assembled signature
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else if (w_match_clr) begin
            r_match <= 1'b0;
        end else if (w_match_load) begin
            r_match <= (r_tt_sig == EXPECTED);
        end
    end

    assign sw.match = r_match;
`else
    logic w_unused_expected;

    assign w_unused_expected = ^EXPECTED;
    assign sw.match          = 1'b0;
`endif

endmodule

// File: tb/tb_tt3_sweep_ctrl.sv
// Self-checking bench for tt3_sweep_ctrl: two instances (settle 4 and settle 1) driving
// a behavioural netlist model; expected sweep results are queued at start and popped on done.
module tb_tt3_sweep_ctrl;

    localparam logic [7:0] EXP_SIG = 8'h39;
`ifdef TT_SWEEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [7:0] sig;
        logic       m;
        int         lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   mode4;
    int   mode1;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    tt3_sweep_ctrl_if sw4 ();
    tt3_sweep_ctrl_if sw1 ();

    tt3_sweep_ctrl #(.SETTLE_CYCLES(4), .EXPECTED(8'h39)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw4)
    );

    tt3_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(8'h39)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw1)
    );

    // Netlist model: 0 -> (in1 & ~in3) ^ in2, 1 -> constant 0, 2 -> constant 1
    function automatic logic net_out(input int mode, input logic a, input logic b, input logic c);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return (a & ~c) ^ b;
        endcase
    endfunction

    assign sw4.dut_out = net_out(mode4, sw4.in1, sw4.in2, sw4.in3);
    assign sw1.dut_out = net_out(mode1, sw1.in1, sw1.in2, sw1.in3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] vin(input int sel);
        return (sel == 1) ? {sw1.in1, sw1.in2, sw1.in3} : {sw4.in1, sw4.in2, sw4.in3};
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) sw1.start = v;
        else          sw4.start = v;
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
    endtask

    // Watch a sweep from the acceptance edge until done; gathers observations only.
    task automatic observe(input int sel, input int k0, input int s, input int budget,
                           output int lat, output int seq_err, output logic [7:0] sig,
                           output logic m, output logic busy_after, output logic busy_gap);
        int k;
        int per;
        logic [2:0] v;
        logic [2:0] ev;
        logic d;
        logic b;
        k = k0;
        per = s + 1;
        lat = -1;
        seq_err = 0;
        busy_gap = 1'b0;
        while (lat < 0 && k < budget) begin
            @(negedge clk);
            k++;
            v = vin(sel);
            d = (sel == 1) ? sw1.done : sw4.done;
            b = (sel == 1) ? sw1.busy : sw4.busy;
            if (k <= 8 * per) begin
                ev = 3'((k - 1) / per);
                if (v !== ev) seq_err++;
            end
            if (b !== 1'b1) busy_gap = 1'b1;
            if (d === 1'b1) lat = k;
        end
        @(negedge clk);
        busy_after = (sel == 1) ? sw1.busy : sw4.busy;
        sig = (sel == 1) ? sw1.tt_sig : sw4.tt_sig;
        m = (sel == 1) ? sw1.match : sw4.match;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw4.start = 1'b0; sw4.abort = 1'b0;
        sw1.start = 1'b0; sw1.abort = 1'b0;
        mode4 = 0; mode1 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (vin(4) !== 3'b000) begin n_fail++; $display("FAIL reset_in: got %b want 000", vin(4)); end
        n_tests++;
        if (sw4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", sw4.busy); end
        n_tests++;
        if (sw4.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", sw4.done); end
        n_tests++;
        if (sw4.tt_sig !== 8'h00) begin n_fail++; $display("FAIL reset_sig: got %h want 00", sw4.tt_sig); end
        n_tests++;
        if (sw4.match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b want 0", sw4.match); end
        n_tests++;
        if (sw1.tt_sig !== 8'h00 || sw1.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_dut1: sig %h busy %b want 00/0", sw1.tt_sig, sw1.busy);
        end
    endtask

    task automatic test_sweep_39();
        int lat, serr; logic [7:0] sig; logic m, ba, bg; exp_t e;
        mode4 = 0;
        pulse_start(4);
        sb_q.push_back('{sig: EXP_SIG, m: CHK, lat: 41});
        observe(4, 0, 4, 200, lat, serr, sig, m, ba, bg);
        e = sb_q.pop_front();
        n_tests++;
        if (lat != e.lat) begin n_fail++; $display("FAIL sweep39_latency: got %0d want %0d", lat, e.lat); end
        n_tests++;
        if (sig !== e.sig) begin n_fail++; $display("FAIL sweep39_sig: got %h want %h", sig, e.sig); end
        n_tests++;
        if (m !== e.m) begin n_fail++; $display("FAIL sweep39_match: got %b want %b", m, e.m); end
        n_tests++;
        if (serr != 0) begin n_fail++; $display("FAIL sweep39_vectors: %0d bad cycles want 0", serr); end
        n_tests++;
        if (ba !== 1'b0 || bg !== 1'b0) begin
            n_fail++; $display("FAIL sweep39_busy: after %b gap %b want 0/0", ba, bg);
        end
    endtask

    task automatic test_const();
        int lat, serr; logic [7:0] sig; logic m, ba, bg; exp_t e;
        for (int c = 1; c <= 2; c++) begin
            mode4 = c;
            pulse_start(4);
            sb_q.push_back('{sig: (c == 2) ? 8'hFF : 8'h00, m: 1'b0, lat: 41});
            observe(4, 0, 4, 200, lat, serr, sig, m, ba, bg);
            e = sb_q.pop_front();
            n_tests++;
            if (sig !== e.sig || lat != e.lat) begin
                n_fail++; $display("FAIL const%0d_sig: got %h lat %0d want %h lat %0d", c - 1, sig, lat, e.sig, e.lat);
            end
            n_tests++;
            if (m !== e.m) begin n_fail++; $display("FAIL const%0d_match: got %b want %b", c - 1, m, e.m); end
            n_tests++;
            if (serr != 0) begin n_fail++; $display("FAIL const%0d_vectors: %0d bad cycles want 0", c - 1, serr); end
        end
        mode4 = 0;
    endtask

    task automatic test_settle1();
        int lat, serr; logic [7:0] sig; logic m, ba, bg; exp_t e;
        mode1 = 0;
        pulse_start(1);
        sb_q.push_back('{sig: EXP_SIG, m: CHK, lat: 17});
        observe(1, 0, 1, 100, lat, serr, sig, m, ba, bg);
        e = sb_q.pop_front();
        n_tests++;
        if (lat != e.lat) begin n_fail++; $display("FAIL settle1_latency: got %0d want %0d", lat, e.lat); end
        n_tests++;
        if (sig !== e.sig || m !== e.m) begin
            n_fail++; $display("FAIL settle1_sig: got %h/%b want %h/%b", sig, m, e.sig, e.m);
        end
        n_tests++;
        if (serr != 0 || ba !== 1'b0) begin
            n_fail++; $display("FAIL settle1_vectors: %0d bad cycles busy_after %b want 0/0", serr, ba);
        end
    endtask

    task automatic test_abort();
        int lat, serr, n_done, n_busy; logic [7:0] sig; logic m, ba, bg; exp_t e;
        mode4 = 0;
        pulse_start(4);
        repeat (16) @(negedge clk);
        n_tests++;
        if (vin(4) !== 3'b011) begin n_fail++; $display("FAIL abort_pre_vec: got %b want 011", vin(4)); end
        sw4.abort = 1'b1;
        @(negedge clk);
        n_tests++;
        if (vin(4) !== 3'b000 || sw4.busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: in %b busy %b want 000/0", vin(4), sw4.busy);
        end
        n_tests++;
        if (sw4.tt_sig !== 8'h20) begin n_fail++; $display("FAIL abort_sig: got %h want 20", sw4.tt_sig); end
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 50; i++) begin
            if (sw4.done === 1'b1) n_done++;
            if (sw4.busy === 1'b1) n_busy++;
            @(negedge clk);
        end
        n_tests++;
        if (n_done != 0 || n_busy != 0) begin
            n_fail++; $display("FAIL abort_quiet: done %0d busy %0d cycles want 0/0", n_done, n_busy);
        end
        // start together with abort in IDLE must still launch a sweep
        sw4.start = 1'b1;
        @(posedge clk);
        #1;
        sw4.start = 1'b0;
        sw4.abort = 1'b0;
        sb_q.push_back('{sig: EXP_SIG, m: CHK, lat: 41});
        observe(4, 0, 4, 200, lat, serr, sig, m, ba, bg);
        e = sb_q.pop_front();
        n_tests++;
        if (lat != e.lat || sig !== e.sig || m !== e.m) begin
            n_fail++; $display("FAIL abort_start_wins: lat %0d sig %h m %b want %0d %h %b", lat, sig, m, e.lat, e.sig, e.m);
        end
    endtask

    task automatic test_start_level();
        int lat, serr; logic [7:0] sig; logic m, ba, bg; exp_t e;
        mode4 = 0;
        @(negedge clk);
        sw4.start = 1'b1;
        @(posedge clk);
        #1;
        sb_q.push_back('{sig: EXP_SIG, m: CHK, lat: 41});
        observe(4, 0, 4, 200, lat, serr, sig, m, ba, bg);
        e = sb_q.pop_front();
        n_tests++;
        if (lat != e.lat || bg !== 1'b0 || serr != 0) begin
            n_fail++; $display("FAIL level_first: lat %0d gap %b bad %0d want %0d/0/0", lat, bg, serr, e.lat);
        end
        n_tests++;
        if (sig !== e.sig || m !== e.m || ba !== 1'b0) begin
            n_fail++; $display("FAIL level_first_res: sig %h m %b busy %b want %h %b 0", sig, m, ba, e.sig, e.m);
        end
        @(negedge clk);
        n_tests++;
        if (sw4.busy !== 1'b1 || sw4.tt_sig !== 8'h00 || vin(4) !== 3'b000) begin
            n_fail++; $display("FAIL level_restart: busy %b sig %h in %b want 1/00/000", sw4.busy, sw4.tt_sig, vin(4));
        end
        sw4.start = 1'b0;
        sb_q.push_back('{sig: EXP_SIG, m: CHK, lat: 41});
        observe(4, 1, 4, 200, lat, serr, sig, m, ba, bg);
        e = sb_q.pop_front();
        n_tests++;
        if (lat != e.lat || sig !== e.sig || m !== e.m || serr != 0) begin
            n_fail++; $display("FAIL level_second: lat %0d sig %h m %b bad %0d want %0d %h %b 0", lat, sig, m, serr, e.lat, e.sig, e.m);
        end
    endtask

    task automatic test_reset_mid();
        int n_done, n_busy;
        mode4 = 0;
        pulse_start(4);
        repeat (20) @(negedge clk);
        n_tests++;
        if (vin(4) !== 3'b011 || sw4.tt_sig !== 8'h20) begin
            n_fail++; $display("FAIL rstmid_pre: in %b sig %h want 011/20", vin(4), sw4.tt_sig);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (vin(4) !== 3'b000 || sw4.busy !== 1'b0 || sw4.done !== 1'b0 ||
            sw4.tt_sig !== 8'h00 || sw4.match !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: in %b busy %b done %b sig %h m %b want all 0",
                               vin(4), sw4.busy, sw4.done, sw4.tt_sig, sw4.match);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sw4.done === 1'b1) n_done++;
            if (sw4.busy === 1'b1) n_busy++;
        end
        n_tests++;
        if (n_done != 0 || n_busy != 0) begin
            n_fail++; $display("FAIL rstmid_idle: done %0d busy %0d cycles want 0/0", n_done, n_busy);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_sweep_39();
        test_const();
        test_settle1();
        test_abort();
        test_start_level();
        test_reset_mid();
        n_tests++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: %0d entries want 0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
